// File: rtl/bp_cache_req_arbiter.sv
// Round-robin arbiter sharing one LCE cache-request port between I-cache (0) and D-cache (1).
// The winner owns the LCE until completion. Optional watchdog: define BP_CACHE_REQ_ARB_TIMEOUT_EN.
module bp_cache_req_arbiter #(
  parameter int req_width_p      = 64,
  parameter int meta_width_p     = 8,
  parameter int timeout_cycles_p = 4096
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [2*req_width_p-1:0]  req_i,
  input  logic [1:0]                req_v_i,
  output logic [1:0]                req_ready_o,
  input  logic [2*meta_width_p-1:0] metadata_i,
  input  logic [1:0]                metadata_v_i,
  output logic [1:0]                complete_o,
  output logic [req_width_p-1:0]    req_o,
  output logic                      req_v_o,
  input  logic                      req_ready_i,
  output logic [meta_width_p-1:0]   metadata_o,
  output logic                      metadata_v_o,
  input  logic                      complete_i,
  output logic                      grant_id_o,
  output logic                      busy_o,
  output logic                      timeout_o
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_META, WAIT_DONE} state_t;

  state_t                  state_reg, state_next;
  logic                    grant_reg, grant_next;
  logic                    ptr_reg, ptr_next;
  logic [req_width_p-1:0]  req_reg, req_next;
  logic [meta_width_p-1:0] meta_reg, meta_next;
  logic                    meta_have_reg, meta_have_next;
  logic                    winner;

  logic [req_width_p-1:0]  req_arr  [2];
  logic [meta_width_p-1:0] meta_arr [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      assign req_arr[gi]  = req_i[gi*req_width_p +: req_width_p];
      assign meta_arr[gi] = metadata_i[gi*meta_width_p +: meta_width_p];
    end
  endgenerate

  // Single requester wins outright; a tie goes to the pointer.
  assign winner = (&req_v_i) ? ptr_reg : req_v_i[1];

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    ptr_next       = ptr_reg;
    req_next       = req_reg;
    meta_next      = meta_reg;
    meta_have_next = meta_have_reg;
    req_ready_o    = 2'b00;
    req_v_o        = 1'b0;
    metadata_v_o   = 1'b0;
    complete_o     = 2'b00;
    case (state_reg)
      IDLE: begin
        if (|req_v_i) begin
          req_ready_o[winner] = reset_n_i;
          state_next          = SEND;
          grant_next          = winner;
          ptr_next            = ~winner;
          req_next            = req_arr[winner];
          meta_have_next      = metadata_v_i[winner];
          if (metadata_v_i[winner]) meta_next = meta_arr[winner];
        end
      end
      SEND: begin
        req_v_o = 1'b1;
        if (!meta_have_reg && metadata_v_i[grant_reg]) begin
          meta_next      = meta_arr[grant_reg];
          meta_have_next = 1'b1;
        end
        if (req_ready_i) state_next = WAIT_META;
      end
      WAIT_META: begin
        if (!meta_have_reg && metadata_v_i[grant_reg]) begin
          meta_next      = meta_arr[grant_reg];
          meta_have_next = 1'b1;
        end
        complete_o[grant_reg] = complete_i;
        // An early completion ends the transaction; any unsent metadata is dropped.
        if (complete_i) begin
          state_next     = IDLE;
          meta_have_next = 1'b0;
        end else if (meta_have_reg) begin
          metadata_v_o = 1'b1;
          state_next   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        complete_o[grant_reg] = complete_i;
        if (complete_i) begin
          state_next     = IDLE;
          meta_have_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg     <= IDLE;
      grant_reg     <= 1'b0;
      ptr_reg       <= 1'b1;
      req_reg       <= '0;
      meta_reg      <= '0;
      meta_have_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      ptr_reg       <= ptr_next;
      req_reg       <= req_next;
      meta_reg      <= meta_next;
      meta_have_reg <= meta_have_next;
    end
  end

  assign busy_o     = (state_reg != IDLE);
  assign grant_id_o = grant_reg;
  assign req_o      = req_reg;
  assign metadata_o = meta_reg;

`ifdef BP_CACHE_REQ_ARB_TIMEOUT_EN
  localparam int               CNT_W   = $clog2(timeout_cycles_p + 1);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(timeout_cycles_p);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(timeout_cycles_p - 1);

  logic [CNT_W-1:0] to_cnt_reg;
  logic             timeout_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      to_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else if (state_next == WAIT_DONE && state_reg != WAIT_DONE) begin
      to_cnt_reg <= '0;
    end else if (state_reg == WAIT_DONE && to_cnt_reg != TO_MAX) begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
      if (to_cnt_reg == TO_LAST) timeout_reg <= 1'b1;
    end
  end

  assign timeout_o = timeout_reg;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
